dm_byte_access_ctrl: RTL and testbench

Initiator-side controller that sits between the core's load/store stage and a byte-wide data-memory port. It carries out byte, halfword and word loads and stores by sequencing one byte per cycle over that port. The byte order is little-endian: byte at address A+k maps to data bits [8k+7:8k]. On completion it returns one response pulse with zero- or sign-extended load data.

---
 rtl/dm_byte_access_ctrl_pkg.sv | 16 +
 rtl/dm_byte_access_ctrl.sv | 110 +++++++++++
 tb/tb_dm_byte_access_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_byte_access_ctrl_pkg.sv
// Shared encodings for the byte-serial data-memory access controller.
// Holds the request size codes and the controller state type.
package dm_byte_access_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/dm_byte_access_ctrl.sv
// Sequences byte/halfword/word loads and stores over a byte-wide memory port,
// one little-endian byte per cycle, then returns a single response pulse.
module dm_byte_access_ctrl
    import dm_byte_access_ctrl_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic          resp_err,
    output logic [31:0]   resp_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    state_t        state;
    logic          we;
    logic          sgn;
    logic          err;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rbuf;
    logic [2:0]    nbytes;
    logic [1:0]    cnt;

    // Bits above the loaded width copy the top data bit only for signed loads.
    function automatic logic [31:0] extend_load(input logic [31:0] data,
                                                input logic [2:0]  n,
                                                input logic        s);
        logic [31:0] r;
        r = data;
        case (n)
            3'd1:    r = {{24{s & data[7]}},  data[7:0]};
            3'd2:    r = {{16{s & data[15]}}, data[15:0]};
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            we     <= 1'b0;
            sgn    <= 1'b0;
            err    <= 1'b0;
            addr   <= '0;
            wdata  <= '0;
            rbuf   <= '0;
            nbytes <= 3'd1;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we     <= req_we;
                        sgn    <= req_signed;
                        addr   <= req_addr;
                        wdata  <= req_wdata;
                        nbytes <= size_to_nbytes(req_size);
                        err    <= (req_size == SZ_RSVD);
                        cnt    <= '0;
                        rbuf   <= '0;
                        state  <= (req_size == SZ_RSVD) ? ST_DONE : ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!we) begin
                        rbuf[{cnt, 3'b000} +: 8] <= mem_rdata;
                    end
                    cnt <= cnt + 2'd1;
                    if ({1'b0, cnt} == nbytes - 3'd1) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Every output decodes only flopped state, so none depends on req_* combinationally.
    assign req_ready  = (state == ST_IDLE);
    assign mem_we     = (state == ST_XFER) && we;
    assign mem_addr   = (state == ST_XFER) ? addr + AW'(cnt) : addr;
    assign mem_wdata  = ((state == ST_XFER) && we) ? wdata[{cnt, 3'b000} +: 8] : 8'h00;
    assign resp_valid = (state == ST_DONE);
    assign resp_err   = resp_valid && err;
    assign resp_rdata = (resp_valid && !we && !err) ? extend_load(rbuf, nbytes, sgn) : 32'h0;

endmodule

// File: tb/tb_dm_byte_access_ctrl.sv
// Directed self-checking bench for dm_byte_access_ctrl with a byte-wide memory model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dm_byte_access_ctrl;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    logic [7:0] mem [0:(1<<AW)-1];

    int nChecks = 0;
    int nErrors = 0;

    dm_byte_access_ctrl #(.AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nChecks++;
        if ({req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_wdata, mem_addr} !==
            {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 12'h000}) begin
            nErrors++;
            $display("[TB] FAIL reset_state: got rdy=%b rv=%b err=%b rd=%h we=%b wd=%h a=%h, expected rdy=1 rv=0 err=0 rd=0 we=0 wd=0 a=0",
                     req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_wdata, mem_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_word_store();
        logic [31:0] wd;
        logic [63:0] got, exp;
        wd = 32'hA1B2C3D4;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 12'h010; req_wdata = wd;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i <= 4) begin
                got = {mem_we, mem_addr, mem_wdata, resp_valid, req_ready};
                exp = {1'b1, 12'(12'h010 + i - 1), wd[8*(i-1) +: 8], 1'b0, 1'b0};
            end else if (i == 5) begin
                got = {resp_valid, resp_err, resp_rdata, mem_we, req_ready};
                exp = {1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
            end else begin
                got = {resp_valid, req_ready, mem_we};
                exp = {1'b0, 1'b1, 1'b0};
            end
            nChecks++;
            if (got !== exp) begin
                nErrors++;
                $display("[TB] FAIL word_store cycle T+%0d: got %h expected %h", i, got, exp);
            end
            req_valid = 1'b0;
        end
        nChecks++;
        if ({mem[12'h013], mem[12'h012], mem[12'h011], mem[12'h010]} !== wd) begin
            nErrors++;
            $display("[TB] FAIL word_store_mem: got %h expected %h",
                     {mem[12'h013], mem[12'h012], mem[12'h011], mem[12'h010]}, wd);
        end
    endtask

    task automatic test_byte_load(input logic sgn, input logic [31:0] expData);
        logic [63:0] got, exp;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_signed = sgn;
        req_addr = 12'h020; req_wdata = 32'hFFFF_FFFF;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) begin
                got = {mem_we, mem_addr, resp_valid, req_ready};
                exp = {1'b0, 12'h020, 1'b0, 1'b0};
            end else if (i == 2) begin
                got = {resp_valid, resp_err, resp_rdata};
                exp = {1'b1, 1'b0, expData};
            end else begin
                got = {req_ready, resp_valid};
                exp = {1'b1, 1'b0};
            end
            nChecks++;
            if (got !== exp) begin
                nErrors++;
                $display("[TB] FAIL byte_load signed=%b cycle T+%0d: got %h expected %h", sgn, i, got, exp);
            end
            req_valid = 1'b0;
        end
    endtask

    task automatic test_half_wrap();
        logic [63:0] got, exp;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b01; req_signed = 1'b1;
        req_addr = 12'hFFF; req_wdata = 32'h0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) begin
                got = {mem_addr, mem_we, resp_valid};
                exp = {12'hFFF, 1'b0, 1'b0};
            end else if (i == 2) begin
                got = {mem_addr, mem_we, resp_valid};
                exp = {12'h000, 1'b0, 1'b0};
            end else begin
                got = {resp_valid, resp_err, resp_rdata};
                exp = {1'b1, 1'b0, 32'hFFFF9234};
            end
            nChecks++;
            if (got !== exp) begin
                nErrors++;
                $display("[TB] FAIL half_wrap cycle T+%0d: got %h expected %h", i, got, exp);
            end
            req_valid = 1'b0;
        end
    endtask

    task automatic test_reserved();
        logic [63:0] got, exp;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_signed = 1'b0;
        req_addr = 12'h040; req_wdata = 32'h5555_AAAA;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            if (i == 1) begin
                got = {resp_valid, resp_err, resp_rdata, mem_we, mem_wdata, req_ready};
                exp = {1'b1, 1'b1, 32'h0, 1'b0, 8'h00, 1'b0};
            end else begin
                got = {resp_valid, resp_err, req_ready, mem_we};
                exp = {1'b0, 1'b0, 1'b1, 1'b0};
            end
            nChecks++;
            if (got !== exp) begin
                nErrors++;
                $display("[TB] FAIL reserved cycle T+%0d: got %h expected %h", i, got, exp);
            end
            req_valid = 1'b0;
        end
        nChecks++;
        if (mem[12'h040] !== 8'h00) begin
            nErrors++;
            $display("[TB] FAIL reserved_mem: got %h expected 00", mem[12'h040]);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got, exp;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b1;
        req_addr = 12'h100; req_wdata = 32'h0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i <= 4) begin
                got = {req_ready, mem_we, mem_addr, resp_valid};
                exp = {1'b0, 1'b0, 12'(12'h100 + i - 1), 1'b0};
            end else if (i == 5) begin
                got = {req_ready, resp_valid, resp_err, resp_rdata};
                exp = {1'b0, 1'b1, 1'b0, 32'h84332211};
            end else if (i == 6) begin
                got = {req_ready, resp_valid, mem_we};
                exp = {1'b1, 1'b0, 1'b0};
            end else if (i == 7) begin
                got = {req_ready, mem_we, mem_addr, mem_wdata};
                exp = {1'b0, 1'b1, 12'h200, 8'h5A};
            end else if (i == 8) begin
                got = {resp_valid, resp_err, resp_rdata, mem_we};
                exp = {1'b1, 1'b0, 32'h0, 1'b0};
            end else begin
                got = {req_ready, resp_valid};
                exp = {1'b1, 1'b0};
            end
            nChecks++;
            if (got !== exp) begin
                nErrors++;
                $display("[TB] FAIL back_to_back cycle T+%0d: got %h expected %h", i, got, exp);
            end
            if (i == 1) begin
                req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
                req_addr = 12'h200; req_wdata = 32'hFFFF_FF5A;
            end
            if (i == 7) req_valid = 1'b0;
        end
        nChecks++;
        if ({mem[12'h201], mem[12'h200]} !== 16'h005A) begin
            nErrors++;
            $display("[TB] FAIL back_to_back_mem: got %h expected 005a", {mem[12'h201], mem[12'h200]});
        end
    endtask

    task automatic test_reset_mid_xfer();
        logic [63:0] got, exp;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 12'h300; req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        got = {mem_we, resp_valid, req_ready, mem_addr};
        exp = {1'b0, 1'b0, 1'b1, 12'h000};
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("[TB] FAIL reset_mid_xfer after reset: got %h expected %h", got, exp);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nChecks++;
            if ({resp_valid, mem_we, req_ready} !== 3'b001) begin
                nErrors++;
                $display("[TB] FAIL reset_mid_xfer idle %0d: got %b expected 001", i,
                         {resp_valid, mem_we, req_ready});
            end
        end
        nChecks++;
        if ({mem[12'h303], mem[12'h302], mem[12'h301], mem[12'h300]} !== 32'h0000BEEF) begin
            nErrors++;
            $display("[TB] FAIL reset_mid_xfer_mem: got %h expected 0000beef",
                     {mem[12'h303], mem[12'h302], mem[12'h301], mem[12'h300]});
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int a = 0; a < (1 << AW); a++) mem[a] <= 8'h00;
        mem[12'h020] <= 8'h80;
        mem[12'hFFF] <= 8'h34;
        mem[12'h000] <= 8'h92;
        mem[12'h100] <= 8'h11;
        mem[12'h101] <= 8'h22;
        mem[12'h102] <= 8'h33;
        mem[12'h103] <= 8'h84;

        test_reset();
        test_word_store();
        test_byte_load(1'b1, 32'hFFFFFF80);
        test_byte_load(1'b0, 32'h00000080);
        test_half_wrap();
        test_reserved();
        test_back_to_back();
        test_reset_mid_xfer();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
